// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and timing defaults for the two-port asynchronous SRAM arbiter.
// The CPU and the data-break/DMA channel share one 32Kx12 RAM through this block.
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_AW        = 15;
    localparam int DEF_DW        = 12;
    localparam int DEF_RD_CYCLES = 2;
    localparam int DEF_WE_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed so one down-counter can hold either strobe length.
    function automatic int cnt_width(input int rd_cycles, input int we_cycles);
        return $clog2(max_int(rd_cycles, we_cycles) + 1);
    endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// Two-input alternating-priority arbiter: a tie goes to the port that was not granted last.
// Purely combinational; the parent registers last_grant.
module ram_rr_arb
    import ram_arbiter_pkg::*;
(
    input  logic enable,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_id    = PORT_CPU;
        if (enable && (cpu_req || dma_req)) begin
            grant_valid = 1'b1;
            if (cpu_req && dma_req) begin
                grant_id = ~last_grant;
            end else begin
                grant_id = dma_req ? PORT_DMA : PORT_CPU;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Sequencer for the shared asynchronous SRAM: arbitrates in IDLE, then drives registered
// CE_N/WE_N strobes with address/data setup and hold, and captures read data.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WE_CYCLES = DEF_WE_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,
    output logic          ram_ce_n,
    output logic          ram_we_n
);

    localparam int CW = cnt_width(RD_CYCLES, WE_CYCLES);

    if (RD_CYCLES < 1) begin : g_bad_rd_cycles
        $error("ram_arbiter: RD_CYCLES must be at least 1");
    end
    if (WE_CYCLES < 1) begin : g_bad_we_cycles
        $error("ram_arbiter: WE_CYCLES must be at least 1");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          gnt_id;

    logic          grant_valid;
    logic          grant_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    ram_rr_arb u_arb (
        .enable      (state == ST_IDLE),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (grant_id == PORT_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    assign busy = (state != ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= PORT_CPU;
            gnt_id     <= PORT_CPU;
            ram_a      <= '0;
            ram_di     <= '0;
            ram_ce_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            rdata      <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        ram_a      <= sel_addr;
                        ram_di     <= sel_wdata;
                        ram_ce_n   <= 1'b0;
                        gnt_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CW'(RD_CYCLES);
                        state      <= sel_we ? ST_WR_SETUP : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == CW'(1)) begin
                        rdata    <= ram_do;
                        cpu_ack  <= (gnt_id == PORT_CPU);
                        dma_ack  <= (gnt_id == PORT_DMA);
                        ram_ce_n <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_WR_SETUP: begin
                    ram_we_n <= 1'b0;
                    cnt      <= CW'(WE_CYCLES);
                    state    <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt == CW'(1)) begin
                        ram_we_n <= 1'b1;
                        state    <= ST_WR_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_WR_HOLD: begin
                    // Address and data stay put this cycle so the RAM sees hold after WE_N rises.
                    cpu_ack  <= (gnt_id == PORT_CPU);
                    dma_ack  <= (gnt_id == PORT_DMA);
                    ram_ce_n <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    ram_ce_n <= 1'b1;
                    ram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a per-access timeline model checked every cycle, directed scenarios
// with literal expectations, and two extra instances covering other strobe lengths.
module tb_ram_arbiter;

    localparam int RD = 2;
    localparam int WE = 2;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        dma_req, dma_we, dma_ack;
    logic [14:0] dma_addr;
    logic [11:0] dma_wdata;
    logic [11:0] rdata;
    logic        busy;
    logic [14:0] ram_a;
    logic [11:0] ram_di, ram_do;
    logic        ram_ce_n, ram_we_n;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    ram_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack),
        .rdata(rdata), .busy(busy), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n)
    );

    logic [11:0] sram [32768];
    always @(posedge clk) if (!ram_ce_n && !ram_we_n) sram[ram_a] <= ram_di;
    assign ram_do = sram[ram_a];

    // Extra instances: index 0 has RD=1/WE=1, index 1 has RD=4/WE=3.
    logic        sw_req [2];
    logic        sw_we [2];
    logic [14:0] sw_addr [2];
    logic [11:0] sw_wdata [2];
    logic        sw_ack [2];
    logic        sw_dack [2];
    logic [11:0] sw_rdata [2];
    logic        sw_busy [2];
    logic [14:0] sw_ram_a [2];
    logic [11:0] sw_ram_di [2];
    logic [11:0] sw_ram_do [2];
    logic        sw_ce_n [2];
    logic        sw_we_n [2];

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SRD = (g == 0) ? 1 : 4;
        localparam int SWE = (g == 0) ? 1 : 3;
        logic [11:0] mem [32768];
        ram_arbiter #(.AW(15), .DW(12), .RD_CYCLES(SRD), .WE_CYCLES(SWE)) u_sw (
            .clk(clk), .reset(reset),
            .cpu_req(sw_req[g]), .cpu_we(sw_we[g]), .cpu_addr(sw_addr[g]),
            .cpu_wdata(sw_wdata[g]), .cpu_ack(sw_ack[g]),
            .dma_req(1'b0), .dma_we(1'b0), .dma_addr(15'd0), .dma_wdata(12'd0),
            .dma_ack(sw_dack[g]),
            .rdata(sw_rdata[g]), .busy(sw_busy[g]), .ram_a(sw_ram_a[g]),
            .ram_di(sw_ram_di[g]), .ram_do(sw_ram_do[g]),
            .ram_ce_n(sw_ce_n[g]), .ram_we_n(sw_we_n[g])
        );
        always @(posedge clk) if (!sw_ce_n[g] && !sw_we_n[g]) mem[sw_ram_a[g]] <= sw_ram_di[g];
        assign sw_ram_do[g] = mem[sw_ram_a[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access occupies phases 1..len after the grant cycle; phase 0 is idle.
    int          m_phase = 0;
    int          m_len   = 1;
    bit          m_port, m_we, m_last;
    logic [14:0] m_addr;
    logic [11:0] m_wdata, m_rdata;
    logic [11:0] m_mem [32768];

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_last  = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
        end else if (m_phase == 0) begin
            if (cpu_req || dma_req) begin
                m_port  = (cpu_req && dma_req) ? !m_last : dma_req;
                m_last  = m_port;
                m_we    = m_port ? dma_we : cpu_we;
                m_addr  = m_port ? dma_addr : cpu_addr;
                m_wdata = m_port ? dma_wdata : cpu_wdata;
                m_len   = m_we ? WE + 3 : RD + 1;
                m_phase = 1;
            end
        end else if (m_phase == m_len) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == m_len) begin
                if (m_we) m_mem[m_addr] = m_wdata;
                else      m_rdata = m_mem[m_addr];
            end
        end
    end

    bit e_act, e_done, e_ce, e_we;
    always @(negedge clk) begin
        if (chk_en) begin
            e_act  = (m_phase != 0);
            e_done = e_act && (m_phase == m_len);
            e_ce   = e_act && (m_phase < m_len);
            e_we   = e_act && m_we && (m_phase >= 2) && (m_phase <= WE + 1);
            check("busy", 32'(busy), 32'(e_act));
            check("cpu_ack", 32'(cpu_ack), 32'(e_done && !m_port));
            check("dma_ack", 32'(dma_ack), 32'(e_done && m_port));
            check("ram_ce_n", 32'(ram_ce_n), 32'(!e_ce));
            check("ram_we_n", 32'(ram_we_n), 32'(!e_we));
            check("ram_a", 32'(ram_a), 32'(m_addr));
            check("ram_di", 32'(ram_di), 32'(m_wdata));
            check("rdata", 32'(rdata), 32'(m_rdata));
            check("ack_overlap", 32'(cpu_ack & dma_ack), 32'd0);
            check("we_without_ce", 32'(!ram_we_n && ram_ce_n), 32'd0);
        end
    end

    // Request fields must be stable while a request is pending.
    logic        p_cpu_req = 0, p_cpu_ack = 0, p_dma_req = 0, p_dma_ack = 0;
    logic [27:0] p_cpu_bus, p_dma_bus;
    always @(posedge clk) begin
        if (!reset && cpu_req && p_cpu_req && !p_cpu_ack)
            assert ({cpu_we, cpu_addr, cpu_wdata} == p_cpu_bus)
                else $error("cpu request fields changed while pending");
        if (!reset && dma_req && p_dma_req && !p_dma_ack)
            assert ({dma_we, dma_addr, dma_wdata} == p_dma_bus)
                else $error("dma request fields changed while pending");
        p_cpu_req = cpu_req;  p_cpu_ack = cpu_ack;  p_cpu_bus = {cpu_we, cpu_addr, cpu_wdata};
        p_dma_req = dma_req;  p_dma_ack = dma_ack;  p_dma_bus = {dma_we, dma_addr, dma_wdata};
    end

    bit          order [$];
    int          ack_cyc [$];
    logic [11:0] cpu_rd;

    task automatic access(input bit port, input bit we, input logic [14:0] a,
                          input logic [11:0] d, output int lat, output int we_low,
                          output logic [11:0] rd);
        bit done = 0;
        @(negedge clk);
        if (port) begin dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
        else      begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        lat = 0; we_low = 0; rd = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!ram_we_n) we_low++;
            if (port ? dma_ack : cpu_ack) begin done = 1; rd = rdata; end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("access_completed", 32'(done), 32'd1);
    endtask

    task automatic run_both(input int n_cpu, input int n_dma);
        int nc = 0, nd = 0, n = 0;
        order.delete();
        ack_cyc.delete();
        @(negedge clk);
        cpu_req = (n_cpu > 0);
        dma_req = (n_dma > 0);
        while ((nc < n_cpu || nd < n_dma) && n < 200) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin
                order.push_back(1'b0); ack_cyc.push_back(n); cpu_rd = rdata; nc++;
                if (nc == n_cpu) cpu_req = 1'b0;
            end
            if (dma_ack) begin
                order.push_back(1'b1); ack_cyc.push_back(n); nd++;
                if (nd == n_dma) dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("both_completed", 32'(nc + nd), 32'(n_cpu + n_dma));
    endtask

    task automatic sweep_access(input int g, input bit we, input logic [14:0] a,
                                input logic [11:0] d, output int lat, output int we_low,
                                output logic [11:0] rd);
        bit done = 0;
        @(negedge clk);
        sw_we[g] = we; sw_addr[g] = a; sw_wdata[g] = d; sw_req[g] = 1'b1;
        lat = 0; we_low = 0; rd = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!sw_we_n[g]) we_low++;
            if (sw_ack[g]) begin done = 1; rd = sw_rdata[g]; end
        end
        sw_req[g] = 1'b0;
        check("sweep_completed", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, wl, n;
        logic [11:0] rd;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        for (int g = 0; g < 2; g++) begin
            sw_req[g] = 0; sw_we[g] = 0; sw_addr[g] = '0; sw_wdata[g] = '0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ce_n", 32'(ram_ce_n), 32'd1);
        check("reset_we_n", 32'(ram_we_n), 32'd1);
        check("reset_ram_a", 32'(ram_a), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;

        // Tie after reset: DMA write wins, then the CPU read sees its data.
        cpu_we = 0; cpu_addr = 15'o00200; cpu_wdata = 12'o0000;
        dma_we = 1; dma_addr = 15'o00200; dma_wdata = 12'o1234;
        run_both(1, 1);
        check("tie_first_dma", 32'(order.size() > 0 && order[0]), 32'd1);
        check("tie_second_cpu", 32'(order.size() > 1 && !order[1]), 32'd1);
        check("tie_cpu_rdata", 32'(cpu_rd), 32'(12'o1234));

        // Streaming reads with both requests held: strict alternation, one idle cycle between.
        dma_we = 0;
        run_both(4, 4);
        check("stream_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8 && i < order.size(); i++)
            check("stream_order", 32'(order[i]), 32'(i % 2 == 0));
        for (int i = 1; i < ack_cyc.size(); i++)
            check("stream_ack_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        check("stream_rdata", 32'(cpu_rd), 32'(12'o1234));

        access(1'b0, 1'b1, 15'o07777, 12'o5252, lat, wl, rd);
        check("wr_latency", 32'(lat), 32'd5);
        check("wr_we_width", 32'(wl), 32'd2);
        access(1'b0, 1'b0, 15'o07777, 12'o0000, lat, wl, rd);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_data", 32'(rd), 32'(12'o5252));

        // Both ends of the 15-bit address range.
        access(1'b1, 1'b1, 15'o70000, 12'o7777, lat, wl, rd);
        access(1'b0, 1'b1, 15'o00000, 12'o0001, lat, wl, rd);
        access(1'b0, 1'b0, 15'o70000, 12'o0000, lat, wl, rd);
        check("wrap_hi_data", 32'(rd), 32'(12'o7777));
        access(1'b1, 1'b0, 15'o00000, 12'o0000, lat, wl, rd);
        check("wrap_lo_data", 32'(rd), 32'(12'o0001));

        // Reset while WE_N is low: strobes release, no ack, then a normal read.
        @(negedge clk);
        cpu_we = 1; cpu_addr = 15'o00100; cpu_wdata = 12'o1111; cpu_req = 1'b1;
        n = 0;
        while (ram_we_n && n < 20) begin @(negedge clk); n++; end
        check("midwr_we_low_seen", 32'(ram_we_n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midwr_we_n", 32'(ram_we_n), 32'd1);
        check("midwr_ce_n", 32'(ram_ce_n), 32'd1);
        check("midwr_no_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("midwr_busy", 32'(busy), 32'd0);
        access(1'b0, 1'b0, 15'o07777, 12'o0000, lat, wl, rd);
        check("post_reset_rd_latency", 32'(lat), 32'd3);
        check("post_reset_rd_data", 32'(rd), 32'(12'o5252));

        // Other strobe lengths: (RD,WE)=(1,1) and (4,3).
        for (int g = 0; g < 2; g++) begin
            sweep_access(g, 1'b1, 15'o12345, 12'o4321, lat, wl, rd);
            check("sweep_wr_latency", 32'(lat), (g == 0) ? 32'd4 : 32'd6);
            check("sweep_we_width", 32'(wl), (g == 0) ? 32'd1 : 32'd3);
            sweep_access(g, 1'b0, 15'o12345, 12'o0000, lat, wl, rd);
            check("sweep_rd_latency", 32'(lat), (g == 0) ? 32'd2 : 32'd5);
            check("sweep_rd_data", 32'(rd), 32'(12'o4321));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the 32Kx12 asynchronous static RAM between two requesters: the CPU (port 0) and the data-break/DMA channel (port 1).
- Generates glitch-free RAM strobes (CE_N, WE_N) with registered address and data setup/hold around every write.
- Captures read data after a programmable access time.
- Sits between the CPU and IO bus logic and the RAM instance in the top level.

Parameters:
- AW, 15, RAM address width: 3-bit field plus 12-bit word.
- DW, 12, data width.
- RD_CYCLES, 2, clocks CE_N is held low before DO is sampled on a read (>=1).
- WE_CYCLES, 2, clocks WE_N is held low on a write (>=1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse when the CPU access completes.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same rules as the CPU port.
- dma_ack  out  1  one-cycle completion pulse for the DMA port.
- rdata  out  DW  read data; valid in the ack cycle and held until the next read completes.
- busy  out  1  high whenever the state is not IDLE.
- ram_a  out  AW  registered RAM address.
- ram_di  out  DW  registered RAM write data.
- ram_do  in  DW  RAM read data (asynchronous).
- ram_ce_n  out  1  RAM chip enable, active low, registered.
- ram_we_n  out  1  RAM write enable, active low, registered.

Behaviour:
- Reset (synchronous, active-high; one clock clk; takes effect at the next edge):
  - State goes to IDLE.
  - ram_ce_n=1, ram_we_n=1, ram_a=0, ram_di=0.
  - rdata=0, cpu_ack=0, dma_ack=0, busy=0.
  - last_grant=CPU, so the first tie goes to DMA.
- States are IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Arbitrate only here. If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_grant (alternation, no starvation).
  - On grant, register ram_a, ram_di and the granted id, set ram_ce_n=0, and update last_grant.
  - Read goes to RD_WAIT with the counter loaded to RD_CYCLES. Write goes to WR_SETUP.
- RD_WAIT: decrement the counter. On the edge where it expires, set rdata<=ram_do, pulse the granted ack, and go to DONE.
- WR_SETUP: one cycle with CE_N low and WE_N high (address/data setup). Then set ram_we_n=0 and go to WR_PULSE with the counter loaded to WE_CYCLES.
- WR_PULSE: hold WE_N low for WE_CYCLES cycles. Then set ram_we_n=1 and go to WR_HOLD.
- WR_HOLD: one cycle with WE_N high and ram_a/ram_di unchanged (hold). Then pulse ack and go to DONE.
- DONE:
  - ack is high for exactly this cycle; ram_ce_n=1.
  - The requester must drop req in this cycle. req is ignored in DONE.
  - Next state is IDLE.
- Latency from req high (cycle 0) to ack high:
  - read: RD_CYCLES+1 (3 with defaults).
  - write: WE_CYCLES+3 (5 with defaults).
  - Back-to-back accesses: the next grant happens in the IDLE cycle after DONE.
- Strobe and bus invariants:
  - ram_a and ram_di change only in IDLE on grant, never while ram_we_n=0.
  - ram_we_n=0 implies ram_ce_n=0.
  - cpu_ack and dma_ack are never high together.
  - rdata is not updated by writes.
- A req that rises in a non-IDLE cycle waits; it is served at the next IDLE.
- Reset mid-write: WE_N returns high at the reset edge, the access is abandoned, and no ack is issued. The RAM word may be corrupt and the requester must reissue.
- Changing addr/we/wdata while req is high and unacked is illegal. The bench flags it with an assertion; the behaviour is undefined.
- Counters must be wide enough for max(RD_CYCLES, WE_CYCLES). A parameter value of 0 is illegal and is flagged at elaboration.

Decomposition:
- Shared include file holds:
  - state encodings (3-bit constants);
  - port-id constants PORT_CPU=0, PORT_DMA=1;
  - default timing constants.
- Natural sub-module: ram_rr_arb, the two-input alternating-priority arbiter. Inputs are the two reqs, last_grant and an enable; outputs are grant_valid and grant_id. Combinational; last_grant is updated by the parent.
- Sequencer, strobe registers and data capture stay in ram_arbiter.

Test Plan:
- Single CPU write then read: write addr 07777 data 5252, then read 07777.
  - Write: ack at cycle 5; WE_N low for exactly 2 cycles with CE_N low and ram_a stable from WR_SETUP through WR_HOLD.
  - Read: ack at cycle 3 and rdata=5252.
- Simultaneous requests after reset:
  - CPU reads 00200 and DMA writes 00200 data 1234, both raised together.
  - DMA is served first; the CPU read then returns 1234.
  - The acks never overlap.
- Both requesters streaming 4 reads each with req held continuously: grants strictly alternate DMA, CPU, DMA, CPU... and there is one IDLE cycle between each DONE and the next grant.
- Field wrap at the address boundary: write 70000 data 7777 and 00000 data 0001, then read both.
  - The reads return 7777 and 0001.
  - The full 15-bit address is carried with no aliasing.
- Reset asserted during WR_PULSE:
  - ram_we_n=1 and ram_ce_n=1 after the reset edge, with no ack.
  - busy=0 in the next cycle, and a fresh read is then accepted normally.
- Parameter sweep RD_CYCLES=1 and 4, WE_CYCLES=1 and 3: read ack latency is 2 and 5, write ack latency is 4 and 6, and the WE_N pulse width equals WE_CYCLES.
